// File: rtl/picorv32_mem_bridge_pkg.sv
// Shared definitions for the PicoRV32-to-word-memory bridge: FSM encoding,
// error response word and the assumed memory read latency.
package picorv32_mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RMW_WAIT = 3'd2,
    ST_WR       = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  localparam logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF;
  localparam int          MEM_RD_LATENCY = 1;

  function automatic logic f_is_full_word(input logic [3:0] strb);
    return (strb == 4'hF);
  endfunction

endpackage

// File: rtl/picorv32_mem_bridge_wstrb_merge.sv
// Byte-lane merge for read-modify-write: lanes with a set strobe take the new
// store data, all other lanes keep the word read back from memory.
module picorv32_mem_bridge_wstrb_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_old,
  input  logic [WIDTH-1:0]   i_new,
  input  logic [WIDTH/8-1:0] i_strb,
  output logic [WIDTH-1:0]   o_word
);

  // Select each byte lane independently from old or new data.
  always_comb begin
    o_word = i_old;
    for (int i = 0; i < WIDTH / 8; i++) begin
      if (i_strb[i]) begin
        o_word[8*i +: 8] = i_new[8*i +: 8];
      end else begin
        o_word[8*i +: 8] = i_old[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/picorv32_mem_bridge.sv
// PicoRV32 native bus to synchronous word memory bridge: full-word stores go
// straight through, sub-word stores become read-modify-write, waits are bounded.
module picorv32_mem_bridge
  import picorv32_mem_bridge_pkg::*;
#(
  parameter int SIZE    = 14,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_valid,
  input  logic [31:0]        cpu_addr,
  input  logic [WIDTH-1:0]   cpu_wdata,
  input  logic [WIDTH/8-1:0] cpu_wstrb,
  output logic               cpu_ready,
  output logic [WIDTH-1:0]   cpu_rdata,
  output logic               cpu_err,
  output logic               mem_en,
  output logic               mem_write,
  output logic [SIZE-1:0]    mem_addr_o,
  output logic [WIDTH-1:0]   mem_wdata_o,
  input  logic [WIDTH-1:0]   mem_rdata_i,
  input  logic               mem_ready_i
);

  // A timeout shorter than the memory latency would fail every access.
  localparam int TO_CYCLES = (TIMEOUT > MEM_RD_LATENCY) ? TIMEOUT : MEM_RD_LATENCY + 1;
  localparam int CW        = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_wdata;
  logic [WIDTH/8-1:0] r_wstrb;
  logic [SIZE-1:0]    r_mem_addr;
  logic               r_cpu_ready, w_cpu_ready_nxt;
  logic [WIDTH-1:0]   r_cpu_rdata, w_cpu_rdata_nxt;
  logic               r_cpu_err, w_cpu_err_nxt;
  logic               r_mem_en, w_mem_en_nxt;
  logic               r_mem_write, w_mem_write_nxt;
  logic [WIDTH-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic               w_accept;
  logic               w_oob;
  logic [WIDTH-1:0]   w_merged;
  logic               w_unused;

  assign w_oob    = |cpu_addr[31:SIZE+2];
  assign w_unused = ^cpu_addr[1:0];

  picorv32_mem_bridge_wstrb_merge #(.WIDTH(WIDTH)) u_merge (
    .i_old  (mem_rdata_i),
    .i_new  (r_wdata),
    .i_strb (r_wstrb),
    .o_word (w_merged)
  );

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_accept        = 1'b0;
    w_cpu_ready_nxt = 1'b0;
    w_cpu_rdata_nxt = {WIDTH{1'b0}};
    w_cpu_err_nxt   = 1'b0;
    w_mem_en_nxt    = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (cpu_valid) begin
          w_accept = 1'b1;
          if (w_oob) begin
            w_state_nxt     = ST_RESP;
            w_cpu_ready_nxt = 1'b1;
            w_cpu_err_nxt   = 1'b1;
          end else if (cpu_wstrb == 4'h0) begin
            w_mem_en_nxt = 1'b1;
            w_cnt_nxt    = {CW{1'b0}};
            w_state_nxt  = ST_RD_WAIT;
          end else if (f_is_full_word(cpu_wstrb)) begin
            w_mem_en_nxt    = 1'b1;
            w_mem_write_nxt = 1'b1;
            w_mem_wdata_nxt = cpu_wdata;
            w_cpu_ready_nxt = 1'b1;
            w_state_nxt     = ST_RESP;
          end else begin
            w_mem_en_nxt = 1'b1;
            w_cnt_nxt    = {CW{1'b0}};
            w_state_nxt  = ST_RMW_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT, ST_RMW_WAIT: begin
        if (mem_ready_i && (r_state == ST_RD_WAIT)) begin
          w_cpu_ready_nxt = 1'b1;
          w_cpu_rdata_nxt = mem_rdata_i;
          w_state_nxt     = ST_RESP;
        end else if (mem_ready_i) begin
          w_mem_en_nxt    = 1'b1;
          w_mem_write_nxt = 1'b1;
          w_mem_wdata_nxt = w_merged;
          w_state_nxt     = ST_WR;
        end else if (r_cnt == CNT_LAST) begin
          w_cpu_ready_nxt = 1'b1;
          w_cpu_rdata_nxt = ERR_RDATA;
          w_cpu_err_nxt   = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_WR: begin
        w_cpu_ready_nxt = 1'b1;
        w_state_nxt     = ST_RESP;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter, request capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_wdata     <= {WIDTH{1'b0}};
      r_wstrb     <= {(WIDTH/8){1'b0}};
      r_mem_addr  <= {SIZE{1'b0}};
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= {WIDTH{1'b0}};
      r_cpu_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= {WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_cpu_err   <= w_cpu_err_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_accept) begin
        r_wdata    <= cpu_wdata;
        r_wstrb    <= cpu_wstrb;
        r_mem_addr <= cpu_addr[SIZE+1:2];
      end else begin
        r_wdata    <= r_wdata;
        r_wstrb    <= r_wstrb;
        r_mem_addr <= r_mem_addr;
      end
    end
  end

  assign cpu_ready   = r_cpu_ready;
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_err     = r_cpu_err;
  assign mem_en      = r_mem_en;
  assign mem_write   = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_picorv32_mem_bridge.sv
// Randomized self-checking bench for picorv32_mem_bridge with a word-memory
// model and a byte-strobe reference store.
module tb_picorv32_mem_bridge;
  import picorv32_mem_bridge_pkg::*;

  localparam int SIZE    = 14;
  localparam int TIMEOUT = 15;
  localparam int RD_LAT  = 2 + MEM_RD_LATENCY;
  localparam int RMW_LAT = 3 + MEM_RD_LATENCY;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_valid = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [3:0]  cpu_wstrb = 4'h0;
  logic cpu_ready, cpu_err, mem_en, mem_write;
  logic [31:0] cpu_rdata, mem_wdata_o;
  logic [SIZE-1:0] mem_addr_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic mem_ready_i = 1'b0;

  bit withhold = 1'b0;
  int en_cnt = 0;
  int wr_cnt = 0;
  logic [SIZE-1:0] last_wr_addr = '0;
  logic [31:0] mem [0:(1<<SIZE)-1];
  logic [31:0] ref_mem [0:15];
  int n_cmp = 0;
  int n_bad = 0;

  picorv32_mem_bridge #(.SIZE(SIZE), .WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .mem_en(mem_en), .mem_write(mem_write),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  always #5 clk = ~clk;

  // Synchronous word memory, one-cycle read latency, optional ready suppression.
  always @(posedge clk) begin
    mem_ready_i <= 1'b0;
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_write) begin
        mem[mem_addr_o] <= mem_wdata_o;
        wr_cnt <= wr_cnt + 1;
        last_wr_addr <= mem_addr_o;
      end else if (!withhold) begin
        mem_rdata_i <= mem[mem_addr_o];
        mem_ready_i <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] ref_store(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (new_w & mask) | (old_w & ~mask);
  endfunction

  // Issue one request at a negedge and wait (bounded) for the completion pulse.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic er, output int lat, output logic r2);
    cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_valid = 1'b1;
    rd = 32'h0; er = 1'b0; lat = 0; r2 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
      end
      if (cpu_ready === 1'b1) begin
        lat = c; rd = cpu_rdata; er = cpu_err;
        break;
      end
    end
    cpu_valid = 1'b0;
    @(negedge clk);
    r2 = cpu_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cpu_ready, cpu_err, mem_en, mem_write} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctl got %b want 0000", {cpu_ready, cpu_err, mem_en, mem_write});
    end
    n_cmp++;
    if ({cpu_rdata, mem_wdata_o, mem_addr_o} !== '0) begin
      n_bad++; $display("FAIL reset_data got %h/%h/%h want 0", cpu_rdata, mem_wdata_o, mem_addr_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd; logic er, r2; int lat, e0, w0;
    e0 = en_cnt; w0 = wr_cnt;
    txn(32'h10, 32'hCAFE_BABE, 4'hF, rd, er, lat, r2);
    ref_mem[4] = 32'hCAFE_BABE;
    n_cmp++;
    if ({lat, er, rd} !== {32'd1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL fw_resp got lat=%0d err=%b rd=%h want 1/0/0", lat, er, rd);
    end
    n_cmp++;
    if ({en_cnt - e0, wr_cnt - w0, 32'(last_wr_addr)} !== {32'd1, 32'd1, 32'd4}) begin
      n_bad++; $display("FAIL fw_mem got en=%0d wr=%0d addr=%0d want 1/1/4", en_cnt - e0, wr_cnt - w0, last_wr_addr);
    end
    txn(32'h10, 32'h0, 4'h0, rd, er, lat, r2);
    n_cmp++;
    if ({rd, er} !== {32'hCAFE_BABE, 1'b0}) begin
      n_bad++; $display("FAIL fr_data got %h err=%b want cafebabe/0", rd, er);
    end
    n_cmp++;
    if ({lat, r2} !== {RD_LAT, 1'b0}) begin
      n_bad++; $display("FAIL fr_timing got lat=%0d ready_after=%b want %0d/0", lat, r2, RD_LAT);
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd; logic er, r2; int lat, e0, w0;
    e0 = en_cnt; w0 = wr_cnt;
    txn(32'h10, 32'h0000_1234, 4'b0011, rd, er, lat, r2);
    ref_mem[4] = ref_store(ref_mem[4], 32'h0000_1234, 4'b0011);
    n_cmp++;
    if ({en_cnt - e0, wr_cnt - w0, lat, er} !== {32'd2, 32'd1, RMW_LAT, 1'b0}) begin
      n_bad++; $display("FAIL rmw_resp got en=%0d wr=%0d lat=%0d err=%b want 2/1/%0d/0", en_cnt - e0, wr_cnt - w0, lat, er, RMW_LAT);
    end
    txn(32'h10, 32'h0, 4'h0, rd, er, lat, r2);
    n_cmp++;
    if (rd !== 32'hCAFE_1234) begin
      n_bad++; $display("FAIL rmw_reread got %h want cafe1234", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic er, r2, oob; logic [3:0] s; int lat, e0, exp_lat, idx;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) continue;
      d = $urandom;
      txn(32'(i * 4), d, 4'hF, rd, er, lat, r2);
      ref_mem[i] = d;
    end
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 15);
      oob = ($urandom_range(0, 7) == 0);
      a = {14'h0, 14'(idx), 2'($urandom)};
      if (oob) a[31:SIZE+2] = 16'($urandom_range(1, 65535));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: s = 4'h0;
        1: s = 4'hF;
        default: s = 4'($urandom);
      endcase
      e0 = en_cnt;
      txn(a, d, s, rd, er, lat, r2);
      if (oob) begin
        exp_lat = 1; exp_rd = 32'h0;
      end else if (s == 4'h0) begin
        exp_lat = RD_LAT; exp_rd = ref_mem[idx];
      end else begin
        exp_lat = (s == 4'hF) ? 1 : RMW_LAT; exp_rd = 32'h0;
        ref_mem[idx] = ref_store(ref_mem[idx], d, s);
      end
      n_cmp++;
      if ({rd, er, lat, r2} !== {exp_rd, oob, exp_lat, 1'b0}) begin
        n_bad++; $display("FAIL rand[%0d] a=%h s=%h got rd=%h err=%b lat=%0d rdy2=%b want %h/%b/%0d/0",
                          n, a, s, rd, er, lat, r2, exp_rd, oob, exp_lat);
      end
      if (oob) begin
        n_cmp++;
        if (en_cnt !== e0) begin
          n_bad++; $display("FAIL rand_oob_en got %0d pulses want 0", en_cnt - e0);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er, r2; int lat, e0;
    e0 = en_cnt;
    txn(32'(1 << (SIZE + 2)), 32'h0, 4'h0, rd, er, lat, r2);
    n_cmp++;
    if ({lat, rd, er, en_cnt - e0} !== {32'd1, 32'h0, 1'b1, 32'd0}) begin
      n_bad++; $display("FAIL oob got lat=%0d rd=%h err=%b en=%0d want 1/0/1/0", lat, rd, er, en_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er, r2; int lat, w0;
    withhold = 1'b1;
    txn(32'h14, 32'h0, 4'h0, rd, er, lat, r2);
    n_cmp++;
    if ({rd, er, lat} !== {ERR_RDATA, 1'b1, TIMEOUT + 1}) begin
      n_bad++; $display("FAIL to_read got rd=%h err=%b lat=%0d want deadbeef/1/%0d", rd, er, lat, TIMEOUT + 1);
    end
    w0 = wr_cnt;
    txn(32'h10, 32'hFFFF_FFFF, 4'b1100, rd, er, lat, r2);
    n_cmp++;
    if ({rd, er, lat, wr_cnt - w0} !== {ERR_RDATA, 1'b1, TIMEOUT + 1, 32'd0}) begin
      n_bad++; $display("FAIL to_rmw got rd=%h err=%b lat=%0d wr=%0d want deadbeef/1/%0d/0", rd, er, lat, wr_cnt - w0, TIMEOUT + 1);
    end
    withhold = 1'b0;
    txn(32'h10, 32'h0, 4'h0, rd, er, lat, r2);
    n_cmp++;
    if (rd !== ref_mem[4]) begin
      n_bad++; $display("FAIL to_unchanged got %h want %h", rd, ref_mem[4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, d; logic er, r2; int lat, w0;
    withhold = 1'b1;
    w0 = wr_cnt;
    cpu_addr = 32'h10; cpu_wdata = 32'h5555_5555; cpu_wstrb = 4'b0101; cpu_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cpu_ready, cpu_err, mem_en, mem_write, cpu_rdata, mem_wdata_o, mem_addr_o} !== '0) begin
      n_bad++; $display("FAIL rst_mid got rdy=%b err=%b en=%b addr=%h want all 0", cpu_ready, cpu_err, mem_en, mem_addr_o);
    end
    cpu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; withhold = 1'b0;
    @(negedge clk);
    d = $urandom;
    txn(32'h14, d, 4'hF, rd, er, lat, r2);
    ref_mem[5] = d;
    txn(32'h14, 32'h0, 4'h0, rd, er, lat, r2);
    n_cmp++;
    if ({rd, er, lat, wr_cnt - w0} !== {d, 1'b0, RD_LAT, 32'd1}) begin
      n_bad++; $display("FAIL rst_recover got rd=%h err=%b lat=%0d wr=%0d want %h/0/%0d/1", rd, er, lat, wr_cnt - w0, d, RD_LAT);
    end
  endtask

  task automatic test_back_to_back();
    int n_rdy, e0, w0; logic prev, consec, bad_rd; logic [31:0] d;
    for (int mode = 0; mode < 2; mode++) begin
      d = $urandom;
      cpu_addr = 32'h18; cpu_wdata = d; cpu_wstrb = (mode == 0) ? 4'h0 : 4'hF;
      cpu_valid = 1'b1;
      n_rdy = 0; prev = 1'b0; consec = 1'b0; bad_rd = 1'b0; e0 = en_cnt; w0 = wr_cnt;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (cpu_ready === 1'b1) begin
          n_rdy++;
          if (prev) consec = 1'b1;
          if (cpu_rdata !== ((mode == 0) ? ref_mem[6] : 32'h0)) bad_rd = 1'b1;
          if (n_rdy == 5) break;
        end
        prev = cpu_ready;
      end
      cpu_valid = 1'b0;
      if (mode == 1) ref_mem[6] = d;
      @(negedge clk);
      n_cmp++;
      if ({n_rdy, en_cnt - e0, consec, bad_rd} !== {32'd5, 32'd5, 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL b2b[%0d] got rdy=%0d en=%0d consec=%b badrd=%b want 5/5/0/0", mode, n_rdy, en_cnt - e0, consec, bad_rd);
      end
      n_cmp++;
      if (wr_cnt - w0 !== ((mode == 0) ? 0 : 5)) begin
        n_bad++; $display("FAIL b2b_wr[%0d] got %0d writes want %0d", mode, wr_cnt - w0, (mode == 0) ? 0 : 5);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_random();
    test_out_of_range();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
